// File: rtl/sram_arbiter_nch.sv
// N-channel arbiter onto the BaseRAM/ExtRAM pair.
// One access at a time: IDLE (arbitrate) -> ACCESS (WAIT_CYCLES strobe cycles)
// -> DONE (one cycle, strobes released, response pulse). Tristate is built above.

// Per-bank pin driver: decodes the shared access state into one bank's pins.
module sram_arbiter_nch_bank (
  input  logic        acc_i,     // ACCESS state and this bank selected
  input  logic        done_i,    // DONE state and this bank selected
  input  logic        sel_i,     // latched bank is this one
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [19:0] waddr_i,
  input  logic [31:0] wdata_i,
  output logic [19:0] addr_o,
  output logic [3:0]  be_n_o,
  output logic        ce_n_o,
  output logic        oe_n_o,
  output logic        we_n_o,
  output logic [31:0] d_o,
  output logic        d_oe_o
);
  // Strobes are only active in ACCESS; write data is kept driven through DONE for hold time.
  always_comb begin
    addr_o = sel_i ? waddr_i : 20'h0;
    be_n_o = acc_i ? ~be_i : 4'hF;
    ce_n_o = ~acc_i;
    oe_n_o = ~(acc_i & ~we_i);
    we_n_o = ~(acc_i & we_i);
    d_o    = wdata_i;
    d_oe_o = we_i & (acc_i | done_i);
  end
endmodule

module sram_arbiter_nch #(
  parameter int NCH         = 2,
  parameter int WAIT_CYCLES = 1,
  parameter int RR_MODE     = 0,
  parameter int BANK_BIT    = 22
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NCH-1:0]    req,
  input  logic [NCH-1:0]    req_we,
  input  logic [NCH*4-1:0]  req_be,
  input  logic [NCH*32-1:0] req_addr,
  input  logic [NCH*32-1:0] req_wdata,
  output logic [NCH-1:0]    gnt,
  output logic [NCH-1:0]    rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              busy,
  output logic [19:0]       base_ram_addr,
  output logic [3:0]        base_ram_be_n,
  output logic              base_ram_ce_n,
  output logic              base_ram_oe_n,
  output logic              base_ram_we_n,
  output logic [31:0]       base_ram_d_o,
  output logic              base_ram_d_oe,
  input  logic [31:0]       base_ram_d_i,
  output logic [19:0]       ext_ram_addr,
  output logic [3:0]        ext_ram_be_n,
  output logic              ext_ram_ce_n,
  output logic              ext_ram_oe_n,
  output logic              ext_ram_we_n,
  output logic [31:0]       ext_ram_d_o,
  output logic              ext_ram_d_oe,
  input  logic [31:0]       ext_ram_d_i
);
  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [NCH-1:0] ONE = NCH'(1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [IW-1:0] win_q, win_d;
  logic [IW-1:0] ptr_q;
  logic [CW-1:0] cnt_q;
  logic          we_q, bank_q;
  logic [3:0]    be_q;
  logic [19:0]   word_q;
  logic [31:0]   wdata_q, rdata_q;
  logic [NCH-1:0] gnt_q;

  logic [31:0] sel_addr, sel_wdata;
  logic [3:0]  sel_be;
  logic        sel_we;
  logic        unused_addr_bits;

  // Winner select: fixed = lowest index; RR = first set bit after ptr_q.
  always_comb begin
    int idx;
    idx   = 0;
    win_d = '0;
    if (RR_MODE != 0) begin
      for (int k = NCH-1; k >= 0; k--) begin
        idx = int'(ptr_q) + 1 + k;
        if (idx >= NCH) idx -= NCH;
        if (req[IW'(idx)]) win_d = IW'(idx);
      end
    end else begin
      for (int k = NCH-1; k >= 0; k--)
        if (req[IW'(k)]) win_d = IW'(k);
    end
  end

  // Mux the winning channel's request fields.
  always_comb begin
    sel_we    = req_we[win_d];
    sel_be    = req_be[{win_d, 2'b00} +: 4];
    sel_addr  = req_addr[{win_d, 5'b00000} +: 32];
    sel_wdata = req_wdata[{win_d, 5'b00000} +: 32];
  end

  // Only the word index and bank bit of the byte address matter here.
  assign unused_addr_bits = ^sel_addr;

  // Access FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (|req) state_d = S_ACCESS;
      S_ACCESS: if (cnt_q == '0) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State, grant latch, wait counter and read capture.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      win_q   <= '0;
      ptr_q   <= IW'(NCH-1);
      cnt_q   <= '0;
      we_q    <= 1'b0;
      bank_q  <= 1'b0;
      be_q    <= 4'h0;
      word_q  <= 20'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= '0;
      case (state_q)
        S_IDLE: if (|req) begin
          win_q   <= win_d;
          gnt_q   <= ONE << win_d;
          we_q    <= sel_we;
          be_q    <= sel_be;
          word_q  <= sel_addr[21:2];
          bank_q  <= sel_addr[BANK_BIT];
          wdata_q <= sel_wdata;
          cnt_q   <= CW'(WAIT_CYCLES-1);
          if (RR_MODE != 0) ptr_q <= win_d;
        end
        S_ACCESS: begin
          if (cnt_q == '0) begin
            if (!we_q) rdata_q <= bank_q ? ext_ram_d_i : base_ram_d_i;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign gnt       = gnt_q;
  assign rsp_valid = (state_q == S_DONE) ? (ONE << win_q) : '0;
  assign rsp_rdata = rdata_q;
  assign busy      = (state_q != S_IDLE);

  sram_arbiter_nch_bank u_base (
    .acc_i(state_q == S_ACCESS && !bank_q), .done_i(state_q == S_DONE && !bank_q),
    .sel_i(!bank_q), .we_i(we_q), .be_i(be_q), .waddr_i(word_q), .wdata_i(wdata_q),
    .addr_o(base_ram_addr), .be_n_o(base_ram_be_n), .ce_n_o(base_ram_ce_n),
    .oe_n_o(base_ram_oe_n), .we_n_o(base_ram_we_n), .d_o(base_ram_d_o),
    .d_oe_o(base_ram_d_oe)
  );

  sram_arbiter_nch_bank u_ext (
    .acc_i(state_q == S_ACCESS && bank_q), .done_i(state_q == S_DONE && bank_q),
    .sel_i(bank_q), .we_i(we_q), .be_i(be_q), .waddr_i(word_q), .wdata_i(wdata_q),
    .addr_o(ext_ram_addr), .be_n_o(ext_ram_be_n), .ce_n_o(ext_ram_ce_n),
    .oe_n_o(ext_ram_oe_n), .we_n_o(ext_ram_we_n), .d_o(ext_ram_d_o),
    .d_oe_o(ext_ram_d_oe)
  );
endmodule

// File: tb/tb_sram_arbiter_nch.sv
// Directed bench: instance A (NCH=2, WAIT=1, fixed), instance B (NCH=4, WAIT=3, RR).
module tb_sram_arbiter_nch;
  logic clk = 1'b0;
  logic resetn;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Instance A signals
  logic [1:0]  a_req, a_we, a_gnt, a_rv;
  logic [7:0]  a_be;
  logic [63:0] a_addr, a_wdata;
  logic [31:0] a_rdata, a_bd_o, a_ed_o;
  logic        a_busy;
  logic [19:0] a_ba, a_ea;
  logic [3:0]  a_bbe, a_ebe;
  logic        a_bce, a_boe, a_bwe, a_bdoe, a_ece, a_eoe, a_ewe, a_edoe;
  logic [31:0] a_bdi = 32'hDEADBEEF;
  logic [31:0] a_edi = 32'h0BADF00D;

  // Instance B signals
  logic [3:0]   b_req, b_we, b_gnt, b_rv;
  logic [15:0]  b_be;
  logic [127:0] b_addr, b_wdata;
  logic [31:0]  b_rdata, b_bd_o, b_ed_o;
  logic         b_busy;
  logic [19:0]  b_ba, b_ea;
  logic [3:0]   b_bbe, b_ebe;
  logic         b_bce, b_boe, b_bwe, b_bdoe, b_ece, b_eoe, b_ewe, b_edoe;
  logic [31:0]  b_bdi = 32'hCAFEF00D;
  logic [31:0]  b_edi = 32'h11223344;

  sram_arbiter_nch #(.NCH(2), .WAIT_CYCLES(1), .RR_MODE(0), .BANK_BIT(22)) u_a (
    .clk(clk), .resetn(resetn), .req(a_req), .req_we(a_we), .req_be(a_be),
    .req_addr(a_addr), .req_wdata(a_wdata), .gnt(a_gnt), .rsp_valid(a_rv),
    .rsp_rdata(a_rdata), .busy(a_busy),
    .base_ram_addr(a_ba), .base_ram_be_n(a_bbe), .base_ram_ce_n(a_bce),
    .base_ram_oe_n(a_boe), .base_ram_we_n(a_bwe), .base_ram_d_o(a_bd_o),
    .base_ram_d_oe(a_bdoe), .base_ram_d_i(a_bdi),
    .ext_ram_addr(a_ea), .ext_ram_be_n(a_ebe), .ext_ram_ce_n(a_ece),
    .ext_ram_oe_n(a_eoe), .ext_ram_we_n(a_ewe), .ext_ram_d_o(a_ed_o),
    .ext_ram_d_oe(a_edoe), .ext_ram_d_i(a_edi));

  sram_arbiter_nch #(.NCH(4), .WAIT_CYCLES(3), .RR_MODE(1), .BANK_BIT(22)) u_b (
    .clk(clk), .resetn(resetn), .req(b_req), .req_we(b_we), .req_be(b_be),
    .req_addr(b_addr), .req_wdata(b_wdata), .gnt(b_gnt), .rsp_valid(b_rv),
    .rsp_rdata(b_rdata), .busy(b_busy),
    .base_ram_addr(b_ba), .base_ram_be_n(b_bbe), .base_ram_ce_n(b_bce),
    .base_ram_oe_n(b_boe), .base_ram_we_n(b_bwe), .base_ram_d_o(b_bd_o),
    .base_ram_d_oe(b_bdoe), .base_ram_d_i(b_bdi),
    .ext_ram_addr(b_ea), .ext_ram_be_n(b_ebe), .ext_ram_ce_n(b_ece),
    .ext_ram_oe_n(b_eoe), .ext_ram_we_n(b_ewe), .ext_ram_d_o(b_ed_o),
    .ext_ram_d_oe(b_edoe), .ext_ram_d_i(b_edi));

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic set_a(input int ch, input logic we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wd);
    a_we[ch] = we; a_be[ch*4 +: 4] = be; a_addr[ch*32 +: 32] = addr; a_wdata[ch*32 +: 32] = wd;
  endtask

  task automatic set_b(input int ch, input logic we, input logic [3:0] be,
                       input logic [31:0] addr, input logic [31:0] wd);
    b_we[ch] = we; b_be[ch*4 +: 4] = be; b_addr[ch*32 +: 32] = addr; b_wdata[ch*32 +: 32] = wd;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 50 && (a_busy || b_busy); i++) cyc();
    checks++;
    if (a_busy !== 1'b0 || b_busy !== 1'b0) begin
      errors++; $display("FAIL wait_idle: busy a=%b b=%b, required 0", a_busy, b_busy);
    end
  endtask

  // T1: reset values, then first read latency with release at cycle 0
  task automatic test_reset();
    resetn = 1'b0;
    a_req = '0; a_we = '0; a_be = '0; a_addr = '0; a_wdata = '0;
    b_req = '0; b_we = '0; b_be = '0; b_addr = '0; b_wdata = '0;
    set_a(0, 1'b0, 4'hF, 32'h8000_0010, 32'h0);
    a_req = 2'b01;
    cyc(); cyc();
    checks++;
    if ({a_gnt, a_rv, a_busy} !== 5'b0 || a_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_out: gnt=%b rv=%b busy=%b rdata=%h, required 0", a_gnt, a_rv, a_busy, a_rdata);
    end
    checks++;
    if ({a_bce, a_boe, a_bwe, a_ece, a_eoe, a_ewe} !== 6'h3F || a_bbe !== 4'hF || a_ebe !== 4'hF
        || a_ba !== 20'h0 || a_bdoe !== 1'b0 || a_edoe !== 1'b0) begin
      errors++; $display("FAIL reset_pins: ce/oe/we=%b be_n=%h/%h addr=%h doe=%b%b",
        {a_bce, a_boe, a_bwe, a_ece, a_eoe, a_ewe}, a_bbe, a_ebe, a_ba, a_bdoe, a_edoe);
    end
    resetn = 1'b1;            // cycle 0
    cyc();                    // cycle 1
    checks++;
    if (a_gnt !== 2'b01 || a_ba !== 20'h4 || a_boe !== 1'b0 || a_bce !== 1'b0 || a_rv !== 2'b00) begin
      errors++; $display("FAIL t1_c1: gnt=%b addr=%h oe_n=%b ce_n=%b rv=%b, required 01/4/0/0/00", a_gnt, a_ba, a_boe, a_bce, a_rv);
    end
    a_req = 2'b00;
    cyc();                    // cycle 2
    checks++;
    if (a_rv !== 2'b01 || a_rdata !== 32'hDEADBEEF || a_gnt !== 2'b00 || a_boe !== 1'b1) begin
      errors++; $display("FAIL t1_c2: rv=%b rdata=%h gnt=%b oe_n=%b, required 01/DEADBEEF/00/1", a_rv, a_rdata, a_gnt, a_boe);
    end
    wait_idle();
  endtask

  // T2: ch1 write to ExtRAM with partial byte enables
  task automatic test_write_ext();
    set_a(1, 1'b1, 4'b0011, 32'h8040_0008, 32'h12345678);
    a_req = 2'b10;            // cycle 0
    cyc();                    // cycle 1
    checks++;
    if (a_gnt !== 2'b10 || a_ewe !== 1'b0 || a_ece !== 1'b0 || a_eoe !== 1'b1 || a_ebe !== 4'b1100
        || a_edoe !== 1'b1 || a_ea !== 20'h2 || a_ed_o !== 32'h12345678) begin
      errors++; $display("FAIL t2_ext: gnt=%b we_n=%b ce_n=%b oe_n=%b be_n=%b doe=%b addr=%h d=%h",
        a_gnt, a_ewe, a_ece, a_eoe, a_ebe, a_edoe, a_ea, a_ed_o);
    end
    checks++;
    if ({a_bce, a_boe, a_bwe} !== 3'b111 || a_bdoe !== 1'b0) begin
      errors++; $display("FAIL t2_base_idle: ce/oe/we=%b doe=%b, required 111/0", {a_bce, a_boe, a_bwe}, a_bdoe);
    end
    a_req = 2'b00;
    cyc();                    // cycle 2: DONE
    checks++;
    if (a_rv !== 2'b10 || a_edoe !== 1'b1 || a_ewe !== 1'b1 || a_ece !== 1'b1) begin
      errors++; $display("FAIL t2_done: rv=%b doe=%b we_n=%b ce_n=%b, required 10/1/1/1", a_rv, a_edoe, a_ewe, a_ece);
    end
    cyc();                    // cycle 3: IDLE
    checks++;
    if (a_edoe !== 1'b0 || a_busy !== 1'b0 || a_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL t2_idle: doe=%b busy=%b rdata=%h, required 0/0/DEADBEEF", a_edoe, a_busy, a_rdata);
    end
  endtask

  // T3 fixed: ch0 wins every arbitration, one grant every 3 cycles
  task automatic test_fixed_priority();
    logic [1:0] exp;
    int n1;
    n1 = 0;
    set_a(0, 1'b0, 4'hF, 32'h8000_0000, 32'h0);
    set_a(1, 1'b0, 4'hF, 32'h8000_0004, 32'h0);
    a_req = 2'b11;
    for (int c = 1; c <= 16; c++) begin
      cyc();
      exp = ((c - 1) % 3 == 0) ? 2'b01 : 2'b00;
      if (a_gnt[1]) n1++;
      checks++;
      if (a_gnt !== exp) begin
        errors++; $display("FAIL t3_fixed c%0d: gnt=%b, required %b", c, a_gnt, exp);
      end
    end
    a_req = 2'b00;
    checks++;
    if (n1 != 0) begin
      errors++; $display("FAIL t3_starve: ch1 grants=%0d, required 0", n1);
    end
    wait_idle();
  endtask

  // T5: reset during a write access releases pins immediately, no response
  task automatic test_reset_mid_access();
    set_a(0, 1'b1, 4'hF, 32'h8000_0100, 32'hAAAA5555);
    a_req = 2'b01;            // cycle 0
    cyc();                    // cycle 1: ACCESS
    checks++;
    if (a_gnt !== 2'b01 || a_bwe !== 1'b0 || a_bdoe !== 1'b1) begin
      errors++; $display("FAIL t5_pre: gnt=%b we_n=%b doe=%b, required 01/0/1", a_gnt, a_bwe, a_bdoe);
    end
    resetn = 1'b0;
    #1;
    checks++;
    if ({a_bce, a_boe, a_bwe} !== 3'b111 || a_bdoe !== 1'b0 || a_busy !== 1'b0 || a_gnt !== 2'b00) begin
      errors++; $display("FAIL t5_abort: ce/oe/we=%b doe=%b busy=%b gnt=%b", {a_bce, a_boe, a_bwe}, a_bdoe, a_busy, a_gnt);
    end
    for (int c = 0; c < 2; c++) begin
      cyc();
      checks++;
      if (a_rv !== 2'b00) begin
        errors++; $display("FAIL t5_norsp: rv=%b, required 00", a_rv);
      end
    end
    resetn = 1'b1;            // cycle 0, req still held
    cyc();
    checks++;
    if (a_gnt !== 2'b01 || a_bwe !== 1'b0 || a_ba !== 20'h40) begin
      errors++; $display("FAIL t5_regrant: gnt=%b we_n=%b addr=%h, required 01/0/40", a_gnt, a_bwe, a_ba);
    end
    a_req = 2'b00;
    cyc();
    checks++;
    if (a_rv !== 2'b01) begin
      errors++; $display("FAIL t5_rsp: rv=%b, required 01", a_rv);
    end
    wait_idle();
  endtask

  // T4: three wait states on a read
  task automatic test_wait_states();
    set_b(2, 1'b0, 4'hF, 32'h0000_0020, 32'h0);
    b_req = 4'b0100;          // cycle 0
    cyc();                    // cycle 1
    checks++;
    if (b_gnt !== 4'b0100) begin
      errors++; $display("FAIL t4_gnt: gnt=%b, required 0100", b_gnt);
    end
    for (int c = 1; c <= 3; c++) begin
      if (c > 1) cyc();
      checks++;
      if (b_boe !== 1'b0 || b_bce !== 1'b0 || b_ba !== 20'h8 || b_rv !== 4'b0) begin
        errors++; $display("FAIL t4_acc c%0d: oe_n=%b ce_n=%b addr=%h rv=%b", c, b_boe, b_bce, b_ba, b_rv);
      end
    end
    cyc();                    // cycle 4
    checks++;
    if (b_boe !== 1'b1 || b_rv !== 4'b0100 || b_rdata !== 32'hCAFEF00D) begin
      errors++; $display("FAIL t4_done: oe_n=%b rv=%b rdata=%h, required 1/0100/CAFEF00D", b_boe, b_rv, b_rdata);
    end
    cyc();                    // cycle 5
    checks++;
    if (b_gnt !== 4'b0000) begin
      errors++; $display("FAIL t4_c5: gnt=%b, required 0000", b_gnt);
    end
    cyc();                    // cycle 6
    checks++;
    if (b_gnt !== 4'b0100) begin
      errors++; $display("FAIL t4_c6: gnt=%b, required 0100", b_gnt);
    end
    b_req = 4'b0000;
    wait_idle();
  endtask

  // T3 RR: two requesters alternate, one grant every 5 cycles
  task automatic test_rr_alternate();
    logic [3:0] exp;
    set_b(0, 1'b0, 4'hF, 32'h0000_0000, 32'h0);
    set_b(1, 1'b0, 4'hF, 32'h0040_0000, 32'h0);
    b_req = 4'b0011;
    for (int c = 1; c <= 16; c++) begin
      cyc();
      exp = ((c - 1) % 5 != 0) ? 4'b0000 : ((((c - 1) / 5) % 2 == 0) ? 4'b0001 : 4'b0010);
      checks++;
      if (b_gnt !== exp) begin
        errors++; $display("FAIL t3_rr c%0d: gnt=%b, required %b", c, b_gnt, exp);
      end
    end
    b_req = 4'b0000;
    wait_idle();
  endtask

  // T6: four-way RR from reset, ch2 leaves after its grant
  task automatic test_rr4_order();
    int order [7] = '{0, 1, 2, 3, 0, 1, 3};
    logic [3:0] exp;
    resetn = 1'b0;
    for (int i = 0; i < 4; i++) set_b(i, 1'b0, 4'hF, 32'h0000_0100 + 32'(i * 4), 32'h0);
    b_req = 4'b1111;
    cyc();
    resetn = 1'b1;            // cycle 0
    for (int c = 1; c <= 31; c++) begin
      cyc();
      exp = ((c - 1) % 5 == 0) ? (4'b0001 << order[(c - 1) / 5]) : 4'b0000;
      checks++;
      if (b_gnt !== exp) begin
        errors++; $display("FAIL t6_rr4 c%0d: gnt=%b, required %b", c, b_gnt, exp);
      end
      if (c == 11) b_req[2] = 1'b0;
    end
    b_req = 4'b0000;
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_write_ext();
    test_fixed_priority();
    test_reset_mid_access();
    test_wait_states();
    test_rr_alternate();
    test_rr4_order();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
